csr_access_unit: RTL and testbench

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit.sv | 155 +++++++++++++++
 tb/tb_csr_access_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_access_unit : sequences one Zicsr instruction (read, optional write,
//                   response) against an external combinational CSR file.
// Revision: 1.0
// ---------------------------------------------------------------------------
module csr_access_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  output logic [XLEN-1:0] trap_pc,
  output logic [11:0]     csr_addr,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q,        state_d;
  logic [2:0]        funct3_q,       funct3_d;
  logic [11:0]       addr_q,         addr_d;
  logic [XLEN-1:0]   rs1_val_q,      rs1_val_d;
  logic [4:0]        rs1_idx_q,      rs1_idx_d;
  logic [XLEN-1:0]   pc_q,           pc_d;
  logic [XLEN-1:0]   csr_wdata_q,    csr_wdata_d;
  logic [XLEN-1:0]   resp_rdata_q,   resp_rdata_d;
  logic              resp_illegal_q, resp_illegal_d;
  logic [XLEN-1:0]   trap_pc_q,      trap_pc_d;

  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   new_val;
  logic              write_req;
  logic              illegal_now;

  // Immediate forms take the 5-bit zimm from the rs1 field, zero-extended.
  always_comb begin
    operand = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    case (funct3_q[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = csr_rdata | operand;
      2'b11:   new_val = csr_rdata & ~operand;
      default: new_val = '0;
    endcase
    write_req   = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
    illegal_now = (funct3_q[1:0] == 2'b00) || csr_illegal
                  || (write_req && (addr_q[11:10] == 2'b11));
  end

  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    rs1_val_d      = rs1_val_q;
    rs1_idx_d      = rs1_idx_q;
    pc_d           = pc_q;
    csr_wdata_d    = csr_wdata_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    trap_pc_d      = trap_pc_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d  = req_funct3;
          addr_d    = req_csr_addr;
          rs1_val_d = req_rs1_val;
          rs1_idx_d = req_rs1_idx;
          pc_d      = req_pc;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        resp_illegal_d = illegal_now;
        resp_rdata_d   = illegal_now ? '0 : csr_rdata;
        trap_pc_d      = illegal_now ? pc_q : '0;
        if (!illegal_now && write_req) begin
          csr_wdata_d = new_val;
          state_d     = S_WRITE;
        end else begin
          state_d     = S_RESP;
        end
      end
      S_WRITE: begin
        csr_wdata_d = '0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_rdata_d   = '0;
          resp_illegal_d = 1'b0;
          trap_pc_d      = '0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      funct3_q       <= '0;
      addr_q         <= '0;
      rs1_val_q      <= '0;
      rs1_idx_q      <= '0;
      pc_q           <= '0;
      csr_wdata_q    <= '0;
      resp_rdata_q   <= '0;
      resp_illegal_q <= 1'b0;
      trap_pc_q      <= '0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      rs1_val_q      <= rs1_val_d;
      rs1_idx_q      <= rs1_idx_d;
      pc_q           <= pc_d;
      csr_wdata_q    <= csr_wdata_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
      trap_pc_q      <= trap_pc_d;
    end
  end

  // Strobes are masked by reset so an aborted request never writes or responds.
  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP) && !reset;
  assign csr_we       = (state_q == S_WRITE) && !reset;
  assign csr_addr     = ((state_q == S_READ) || (state_q == S_WRITE)) ? addr_q : 12'd0;
  assign csr_wdata    = csr_wdata_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;
  assign trap_pc      = trap_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_csr_access_unit : randomized bench with a transaction-level CSR model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_csr_access_unit;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_csr_addr;
  logic [XLEN-1:0] req_rs1_val;
  logic [4:0]      req_rs1_idx;
  logic [XLEN-1:0] req_pc;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;
  logic [XLEN-1:0] trap_pc;
  logic [11:0]     csr_addr;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  csr_access_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_val(req_rs1_val),
    .req_rs1_idx(req_rs1_idx), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_illegal(resp_illegal), .trap_pc(trap_pc),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  // CSR file environment seen by the DUT
  logic [XLEN-1:0] csr_mem   [0:4095];
  logic [XLEN-1:0] model_mem [0:4095];
  bit              ill_map   [0:4095];
  assign csr_rdata   = csr_mem[csr_addr];
  assign csr_illegal = ill_map[csr_addr];
  always @(posedge clk) if (csr_we) csr_mem[csr_addr] = csr_wdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: what the current request must produce, and when.
  bit              m_busy = 0;
  int              m_k, m_acc = 0;
  bit              m_wr, m_ill;
  logic [11:0]     m_addr;
  logic [XLEN-1:0] m_old, m_nv, m_pc, m_op;
  bit              m_wreq, was_busy, e_we, e_valid;
  logic [11:0]     e_addr;
  // Observations of the current transaction
  int              obs_we, obs_lat, obs_vcyc, obs_hs = 0;
  bit              obs_unstable, obs_ill;
  logic [XLEN-1:0] obs_wdata, obs_rdata, obs_trap;

  always @(negedge clk) begin
    if (reset) begin
      chk("we_in_reset", {63'b0, csr_we}, 64'd0);
      if (csr_we) obs_we++;
      m_busy = 0;
    end else begin
      was_busy = m_busy;
      if (m_busy) m_k++;
      e_we    = m_busy && m_wr && (m_k == 2);
      e_valid = m_busy && (m_k >= (m_wr ? 3 : 2));
      e_addr  = (m_busy && (m_k <= (m_wr ? 2 : 1))) ? m_addr : 12'd0;
      chk("req_ready",  {63'b0, req_ready},  {63'b0, !m_busy});
      chk("resp_valid", {63'b0, resp_valid}, {63'b0, e_valid});
      chk("csr_we",     {63'b0, csr_we},     {63'b0, e_we});
      chk("csr_addr",   {52'b0, csr_addr},   {52'b0, e_addr});
      if (e_we) chk("csr_wdata", csr_wdata, m_nv);
      if (e_valid) begin
        chk("resp_illegal", {63'b0, resp_illegal}, {63'b0, m_ill});
        chk("resp_rdata",   resp_rdata, m_ill ? 64'd0 : m_old);
        chk("trap_pc",      trap_pc,    m_ill ? m_pc  : 64'd0);
      end
      if (m_busy) begin
        if (csr_we) begin obs_we++; obs_wdata = csr_wdata; end
        if (resp_valid) begin
          if (obs_lat < 0) begin
            obs_lat = m_k; obs_rdata = resp_rdata; obs_ill = resp_illegal; obs_trap = trap_pc;
          end else if (obs_rdata !== resp_rdata || obs_ill !== resp_illegal || obs_trap !== trap_pc) begin
            obs_unstable = 1;
          end
          obs_vcyc++;
        end
      end
      if (e_we) model_mem[m_addr] = m_nv;
      if (e_valid && resp_ready) begin m_busy = 0; obs_hs++; end
      if (!was_busy && req_valid) begin
        m_busy = 1; m_k = 0; m_acc++;
        m_addr = req_csr_addr; m_pc = req_pc;
        m_op   = req_funct3[2] ? {59'b0, req_rs1_idx} : req_rs1_val;
        m_wreq = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
        m_ill  = (req_funct3[1:0] == 2'b00) || ill_map[req_csr_addr]
                 || (m_wreq && req_csr_addr[11:10] == 2'b11);
        m_old  = model_mem[req_csr_addr];
        case (req_funct3[1:0])
          2'b01:   m_nv = m_op;
          2'b10:   m_nv = m_old | m_op;
          default: m_nv = m_old & ~m_op;
        endcase
        m_wr = m_wreq && !m_ill;
        obs_we = 0; obs_lat = -1; obs_vcyc = 0; obs_unstable = 0;
        obs_wdata = '0; obs_rdata = '0; obs_ill = 0; obs_trap = '0;
      end
    end
  end

  // Consumer back-pressure
  int stall = 0;
  bit rr_rand = 0;
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin resp_ready = 1'b0; stall--; end
      else resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic set_csr(input logic [11:0] a, input logic [63:0] v, input bit ill);
    csr_mem[a] = v; model_mem[a] = v; ill_map[a] = ill;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 100) begin @(posedge clk); #1; n++; end
    if (m_busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [2:0] f, input logic [11:0] a, input logic [63:0] v,
                       input logic [4:0] idx, input logic [63:0] pc);
    int start = m_acc;
    int n = 0;
    wait_idle();
    req_funct3 = f; req_csr_addr = a; req_rs1_val = v; req_rs1_idx = idx; req_pc = pc;
    req_valid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (m_acc == start && n < 50);
    req_valid = 1'b0;
    if (m_acc == start) chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_req(input logic [2:0] f, input logic [11:0] a, input logic [63:0] v,
                         input logic [4:0] idx, input logic [63:0] pc);
    issue(f, a, v, idx, pc);
    wait_idle();
  endtask

  logic [11:0] pool [8];
  int hs0;

  initial begin
    pool[0] = 12'h140; pool[1] = 12'h100; pool[2] = 12'h300; pool[3] = 12'hC00;
    pool[4] = 12'hC01; pool[5] = 12'h341; pool[6] = 12'h7C0; pool[7] = 12'hF11;
    for (int i = 0; i < 4096; i++) set_csr(i[11:0], {$urandom, $urandom}, 1'b0);
    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0;
    req_rs1_val = '0; req_rs1_idx = '0; req_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",    {63'b0, req_ready},    64'd1);
    chk("rst_resp_valid",   {63'b0, resp_valid},   64'd0);
    chk("rst_csr_we",       {63'b0, csr_we},       64'd0);
    chk("rst_csr_addr",     {52'b0, csr_addr},     64'd0);
    chk("rst_csr_wdata",    csr_wdata,             64'd0);
    chk("rst_resp_rdata",   resp_rdata,            64'd0);
    chk("rst_resp_illegal", {63'b0, resp_illegal}, 64'd0);
    chk("rst_trap_pc",      trap_pc,               64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // CSRRW with write
    set_csr(12'h140, 64'h5, 1'b0);
    run_req(3'b001, 12'h140, 64'hDEAD, 5'd7, 64'h1000);
    chk("rw_we_count", obs_we,    1);
    chk("rw_wdata",    obs_wdata, 64'hDEAD);
    chk("rw_latency",  obs_lat,   3);
    chk("rw_rdata",    obs_rdata, 64'h5);
    chk("rw_csrfile",  csr_mem[12'h140], 64'hDEAD);

    // CSRRS with rs1=x0: read only
    set_csr(12'h100, 64'h22, 1'b0);
    run_req(3'b010, 12'h100, 64'hFFFF, 5'd0, 64'h1004);
    chk("rs0_we_count", obs_we,    0);
    chk("rs0_latency",  obs_lat,   2);
    chk("rs0_rdata",    obs_rdata, 64'h22);

    // CSRRCI clearing bits 1:0
    set_csr(12'h300, 64'hF, 1'b0);
    run_req(3'b111, 12'h300, 64'h0, 5'd3, 64'h1008);
    chk("rci_wdata",   obs_wdata, 64'hC);
    chk("rci_rdata",   obs_rdata, 64'hF);

    // Access fault from the CSR file
    set_csr(12'h341, 64'h99, 1'b1);
    run_req(3'b001, 12'h341, 64'h1234, 5'd1, 64'h8000_0010);
    chk("flt_we_count", obs_we,   0);
    chk("flt_illegal",  obs_ill,  1);
    chk("flt_rdata",    obs_rdata, 64'd0);
    chk("flt_trap_pc",  obs_trap, 64'h8000_0010);
    chk("flt_latency",  obs_lat,  2);
    ill_map[12'h341] = 0;

    // Reserved funct3 and read-only space
    run_req(3'b100, 12'h140, 64'h1, 5'd1, 64'h2000);
    chk("f100_illegal", obs_ill, 1);
    set_csr(12'hC00, 64'h77, 1'b0);
    run_req(3'b001, 12'hC00, 64'h1, 5'd1, 64'h2004);
    chk("ro_rw_illegal", obs_ill, 1);
    chk("ro_rw_we",      obs_we,  0);
    run_req(3'b010, 12'hC00, 64'h1, 5'd0, 64'h2008);
    chk("ro_rs_illegal", obs_ill,   0);
    chk("ro_rs_rdata",   obs_rdata, 64'h77);

    // Consumer stalls the response
    hs0 = obs_hs;
    stall = 10;
    run_req(3'b001, 12'h140, 64'hABC, 5'd2, 64'h3000);
    chk("stall_hs",       obs_hs - hs0,       1);
    chk("stall_held",     {63'b0, obs_vcyc >= 5}, 64'd1);
    chk("stall_unstable", {63'b0, obs_unstable},  64'd0);

    // Reset while in READ
    hs0 = obs_hs;
    issue(3'b001, 12'h140, 64'h55, 5'd2, 64'h3004);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstrd_ready", {63'b0, req_ready}, 64'd1);
    repeat (4) begin @(posedge clk); #1; end
    chk("rstrd_we",    obs_we,        0);
    chk("rstrd_hs",    obs_hs - hs0,  0);

    // Randomized traffic
    rr_rand = 1;
    for (int t = 0; t < 200; t++) begin
      logic [11:0] a;
      a = pool[$urandom_range(0, 7)];
      ill_map[a] = ($urandom_range(0, 7) == 0);
      issue($urandom_range(0, 7), a, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            {$urandom, $urandom});
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end
      wait_idle();
    end
    repeat (3) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
